// File: rtl/nibbler_pc_sequencer.sv
// Fetch/execute sequencer for the Nibbler core: drives the program counter, latches ir/opr, resolves jumps.
// Optional build macro NIBBLER_SINGLE_STEP_EN adds a `step` input that gates each fetch on a rising edge.
module nibbler_pc_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
`ifdef NIBBLER_SINGLE_STEP_EN
  input  logic        step,
`endif
  input  logic [7:0]  prog_byte,
  input  logic        flag_c,
  input  logic        flag_z,
  output logic        pc_enable,
  output logic        pc_clr,
  output logic        pc_load,
  output logic [11:0] pc_target,
  output logic [7:0]  ir,
  output logic [7:0]  opr,
  output logic        exec_strobe,
  output logic        halted
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_OPERAND,
    S_EXEC,
    S_HALT
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_ir;
  logic [7:0]  r_opr;
  logic        w_ld_ir;
  logic        w_ld_opr;
  logic        w_step_ok;
  logic [3:0]  w_opcode;
  logic        w_is_jump;
  logic        w_taken;

  assign w_opcode  = r_ir[7:4];
  assign ir        = r_ir;
  assign opr       = r_opr;
  assign pc_target = {r_ir[3:0], r_opr};

`ifdef NIBBLER_SINGLE_STEP_EN
  logic r_step_d;
  logic r_step_pend;
  logic w_step_rise;

  assign w_step_rise = step & ~r_step_d;
  assign w_step_ok   = r_step_pend | w_step_rise;

  // An edge seen mid-instruction is held until the next FETCH so no step is lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_step_d    <= 1'b0;
      r_step_pend <= 1'b0;
    end else begin
      r_step_d <= step;
      if (r_state == S_IDLE)
        r_step_pend <= 1'b0;
      else if (r_state == S_FETCH && run && w_step_ok)
        r_step_pend <= 1'b0;
      else
        r_step_pend <= r_step_pend | w_step_rise;
    end
  end
`else
  assign w_step_ok = 1'b1;
`endif

  always_comb begin
    w_is_jump = 1'b1;
    w_taken   = 1'b0;
    case (w_opcode)
      4'h8:    w_taken = 1'b1;
      4'h9:    w_taken = flag_z;
      4'hA:    w_taken = ~flag_z;
      4'hB:    w_taken = flag_c;
      4'hC:    w_taken = ~flag_c;
      default: w_is_jump = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_ir    <= 8'h00;
      r_opr   <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      if (w_ld_ir)
        r_ir <= prog_byte;
      if (w_ld_opr)
        r_opr <= prog_byte;
    end
  end

  // Only one of pc_enable/pc_clr/pc_load is ever high, so the PC never arbitrates.
  always_comb begin
    w_state_nxt = r_state;
    pc_enable   = 1'b0;
    pc_clr      = 1'b0;
    pc_load     = 1'b0;
    exec_strobe = 1'b0;
    halted      = 1'b0;
    w_ld_ir     = 1'b0;
    w_ld_opr    = 1'b0;
    case (r_state)
      S_IDLE: begin
        pc_clr = 1'b1;
        if (run)
          w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (run && w_step_ok) begin
          pc_enable   = 1'b1;
          w_ld_ir     = 1'b1;
          w_state_nxt = S_OPERAND;
        end
      end
      S_OPERAND: begin
        pc_enable   = 1'b1;
        w_ld_opr    = 1'b1;
        w_state_nxt = S_EXEC;
      end
      S_EXEC: begin
        w_state_nxt = S_FETCH;
        if (w_opcode == 4'hF)
          w_state_nxt = S_HALT;
        else if (w_is_jump)
          pc_load = w_taken;
        else
          exec_strobe = 1'b1;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_nibbler_pc_sequencer.sv
// Bench for nibbler_pc_sequencer: behavioural PC + ROM, scoreboard of expected strobes/loads plus directed checks.
module tb_nibbler_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        run = 1'b0;
  logic        step = 1'b0;
  logic [7:0]  prog_byte;
  logic        flag_c = 1'b0;
  logic        flag_z = 1'b0;
  logic        pc_enable, pc_clr, pc_load, exec_strobe, halted;
  logic [11:0] pc_target;
  logic [7:0]  ir, opr;

  logic [11:0] pc = 12'h000;
  logic [7:0]  rom [4096];

  int n_checks = 0;
  int n_pass   = 0;
  int n_strobe = 0;

  typedef struct packed {
    logic        is_load;
    logic [7:0]  ir;
    logic [7:0]  opr;
    logic [11:0] val;
  } ev_t;
  ev_t sb_q[$];

  always #5 clk = ~clk;

  nibbler_pc_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
`ifdef NIBBLER_SINGLE_STEP_EN
    .step        (step),
`endif
    .prog_byte   (prog_byte),
    .flag_c      (flag_c),
    .flag_z      (flag_z),
    .pc_enable   (pc_enable),
    .pc_clr      (pc_clr),
    .pc_load     (pc_load),
    .pc_target   (pc_target),
    .ir          (ir),
    .opr         (opr),
    .exec_strobe (exec_strobe),
    .halted      (halted)
  );

  // Program counter with load > reset > enable priority, ROM read asynchronously.
  always @(posedge clk) begin
    if (pc_load)        pc <= pc_target;
    else if (pc_clr)    pc <= 12'h000;
    else if (pc_enable) pc <= pc + 12'h001;
  end
  assign prog_byte = rom[pc];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (reset && (exec_strobe || pc_load)) begin
      ev_t e;
      if (exec_strobe) n_strobe++;
      chk("event_expected", int'(sb_q.size() > 0), 1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("event_kind", int'(pc_load), int'(e.is_load));
        if (e.is_load) begin
          chk("load_target", int'(pc_target), int'(e.val));
        end else begin
          chk("strobe_ir", int'(ir), int'(e.ir));
          chk("strobe_opr", int'(opr), int'(e.opr));
          chk("strobe_pc", int'(pc), int'(e.val));
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_strobe(input logic [7:0] i, input logic [7:0] o, input logic [11:0] p);
    sb_q.push_back('{is_load: 1'b0, ir: i, opr: o, val: p});
  endtask

  task automatic push_load(input logic [11:0] t);
    sb_q.push_back('{is_load: 1'b1, ir: 8'h00, opr: 8'h00, val: t});
  endtask

  task automatic clear_rom;
    for (int i = 0; i < 4096; i++) rom[i] = 8'hF0;
  endtask

  task automatic do_reset;
    reset  = 1'b0;
    run    = 1'b0;
    step   = 1'b0;
    flag_c = 1'b0;
    flag_z = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic wait_halt(input int budget);
    int n = 0;
    while (!halted && n < budget) begin
      tick();
      n++;
    end
    chk("halt_reached", int'(halted), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_rom();
    #3;
    chk("rst_ir", int'(ir), 8'h00);
    chk("rst_opr", int'(opr), 8'h00);
    chk("rst_pc_enable", int'(pc_enable), 0);
    chk("rst_pc_load", int'(pc_load), 0);
    chk("rst_exec_strobe", int'(exec_strobe), 0);
    chk("rst_halted", int'(halted), 0);
    chk("rst_pc_clr", int'(pc_clr), 1);
    do_reset();
    chk("idle_pc_clr", int'(pc_clr), 1);

`ifdef NIBBLER_SINGLE_STEP_EN
    rom[0] = 8'h12; rom[1] = 8'h34; rom[2] = 8'h20; rom[3] = 8'h01;
    run = 1'b1;
    repeat (6) tick();
    chk("step_low_pc", int'(pc), 12'h000);
    chk("step_low_enable", int'(pc_enable), 0);
    push_strobe(8'h12, 8'h34, 12'h002);
    push_strobe(8'h20, 8'h01, 12'h004);
    step = 1'b1; tick(); step = 1'b0;
    repeat (6) tick();
    chk("step1_pc", int'(pc), 12'h002);
    step = 1'b1; tick(); step = 1'b0;
    repeat (6) tick();
    chk("step2_pc", int'(pc), 12'h004);
    chk("step_strobe_count", n_strobe, 2);
`else
    // Two datapath ops then HALT.
    rom[0] = 8'h12; rom[1] = 8'h34; rom[2] = 8'h20; rom[3] = 8'h01;
    push_strobe(8'h12, 8'h34, 12'h002);
    push_strobe(8'h20, 8'h01, 12'h004);
    run = 1'b1;
    tick(); chk("seq_pc0", int'(pc), 12'h000);
    tick(); chk("seq_pc1", int'(pc), 12'h001);
    tick(); chk("seq_pc2", int'(pc), 12'h002);
    wait_halt(30);
    chk("seq_halt_pc", int'(pc), 12'h006);
    repeat (3) tick();
    chk("seq_frozen_pc", int'(pc), 12'h006);
    chk("seq_count", n_strobe, 2);

    // JMP 0xABC, HALT there.
    clear_rom(); do_reset();
    rom[0] = 8'h8A; rom[1] = 8'hBC;
    push_load(12'hABC);
    run = 1'b1;
    wait_halt(30);
    chk("jmp_halt_pc", int'(pc), 12'hABE);
    chk("jmp_halt_ir", int'(ir), 8'hF0);
    chk("jmp_no_strobe", n_strobe, 2);

    // JZ 0x005 untaken (Z=0) then taken (Z=1).
    clear_rom(); do_reset();
    rom[0] = 8'h90; rom[1] = 8'h05; rom[2] = 8'h90; rom[3] = 8'h05;
    push_load(12'h005);
    run = 1'b1;
    repeat (4) tick();
    chk("jz_untaken_pc", int'(pc), 12'h002);
    flag_z = 1'b1;
    wait_halt(30);
    chk("jz_taken_halt_pc", int'(pc), 12'h007);

    // Pause while in OPERAND: instruction finishes, FETCH holds at PC 2.
    clear_rom(); do_reset();
    rom[0] = 8'h12; rom[1] = 8'h34;
    push_strobe(8'h12, 8'h34, 12'h002);
    run = 1'b1;
    repeat (2) tick();
    run = 1'b0;
    repeat (2) tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("pause_pc", int'(pc), 12'h002);
    end
    chk("pause_no_enable", int'(pc_enable), 0);
    run = 1'b1;
    wait_halt(30);
    chk("pause_halt_pc", int'(pc), 12'h004);

    // HALT at 0xFFF with operand from 0x000, PC wraps; then async reset.
    clear_rom(); do_reset();
    rom[0] = 8'h8F; rom[1] = 8'hFF;
    push_load(12'hFFF);
    run = 1'b1;
    wait_halt(30);
    chk("wrap_pc", int'(pc), 12'h001);
    chk("wrap_ir", int'(ir), 8'hF0);
    chk("wrap_opr", int'(opr), 8'h8F);
    repeat (5) tick();
    chk("wrap_frozen_pc", int'(pc), 12'h001);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_halted", int'(halted), 0);
    chk("async_rst_pc_clr", int'(pc_clr), 1);
    chk("async_rst_ir", int'(ir), 8'h00);
    tick();
    chk("async_rst_pc", int'(pc), 12'h000);
    reset = 1'b1;

    // Reset mid-instruction discards it without a strobe.
    clear_rom(); do_reset();
    rom[0] = 8'h12; rom[1] = 8'h34;
    run = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    #1;
    chk("mid_rst_enable", int'(pc_enable), 0);
    chk("mid_rst_pc_clr", int'(pc_clr), 1);
    repeat (3) tick();
    reset = 1'b1;
    run = 1'b0;
    repeat (3) tick();
    chk("mid_rst_idle_pc", int'(pc), 12'h000);
    chk("mid_rst_no_strobe", n_strobe, 3);
`endif

    chk("sb_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
